pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit_if.sv | 22 ++
 rtl/pc_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and the memory (slave).
// The request is held with a stable address until the memory acknowledges it.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: issues one instruction-memory request per strobe and
// delivers each fetched word to the instruction register with its PC and PC+4.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            strobe,
  input  logic            stall,
  input  logic            redirect,
  input  logic [31:0]     redirect_pc,
  input  logic            halt,
  pc_fetch_unit_if.master imem,
  output logic [31:0]     ir_din,
  output logic            ir_ld,
  output logic [31:0]     pc_out,
  output logic [31:0]     npc_out,
  output logic            halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_LOAD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] target_r, target_s;
  logic        redirect_pend_r, redirect_pend_s;
  logic        halt_pend_r, halt_pend_s;
  logic [31:0] ir_buf_r, ir_buf_s;
  logic [31:0] pc_out_r, pc_out_s;
  logic [31:0] npc_out_r, npc_out_s;
  logic        imem_req_r;
  logic        ir_ld_r;
  logic        halted_r;
  logic [31:0] pc_plus4_s;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  assign pc_plus4_s = pc_r + 32'd4;

  // Next-state and next-datapath values; redirects and halts seen mid-fetch are parked
  // in pending registers so the in-flight word is always delivered first.
  always_comb begin
    state_s         = state_r;
    pc_s            = pc_r;
    target_s        = target_r;
    redirect_pend_s = redirect_pend_r;
    halt_pend_s     = halt_pend_r;
    ir_buf_s        = ir_buf_r;
    pc_out_s        = pc_out_r;
    npc_out_s       = npc_out_r;
    case (state_r)
      S_IDLE: begin
        if (halt || halt_pend_r) begin
          state_s = S_HALT;
        end else if (redirect) begin
          pc_s = align_word(redirect_pc);
        end else if (strobe && !stall) begin
          state_s = S_REQ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (redirect) begin
          redirect_pend_s = 1'b1;
          target_s        = align_word(redirect_pc);
        end else begin
          redirect_pend_s = redirect_pend_r;
        end
        if (halt) begin
          halt_pend_s = 1'b1;
        end else begin
          halt_pend_s = halt_pend_r;
        end
        // Delivery values are captured at the ack edge so they are already on the
        // outputs during the single LOAD cycle.
        if (imem.imem_ack) begin
          state_s   = S_LOAD;
          ir_buf_s  = imem.imem_rdata;
          pc_out_s  = pc_r;
          npc_out_s = pc_plus4_s;
        end else begin
          state_s = S_REQ;
        end
      end
      S_LOAD: begin
        state_s         = S_IDLE;
        redirect_pend_s = 1'b0;
        if (redirect) begin
          pc_s = align_word(redirect_pc);
        end else if (redirect_pend_r) begin
          pc_s = target_r;
        end else begin
          pc_s = pc_plus4_s;
        end
        if (halt) begin
          halt_pend_s = 1'b1;
        end else begin
          halt_pend_s = halt_pend_r;
        end
      end
      S_HALT: begin
        state_s = S_HALT;
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered output flags.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r         <= S_IDLE;
      pc_r            <= RESET_PC;
      target_r        <= 32'h0000_0000;
      redirect_pend_r <= 1'b0;
      halt_pend_r     <= 1'b0;
      ir_buf_r        <= 32'h0000_0000;
      pc_out_r        <= 32'h0000_0000;
      npc_out_r       <= 32'h0000_0000;
      imem_req_r      <= 1'b0;
      ir_ld_r         <= 1'b0;
      halted_r        <= 1'b0;
    end else begin
      state_r         <= state_s;
      pc_r            <= pc_s;
      target_r        <= target_s;
      redirect_pend_r <= redirect_pend_s;
      halt_pend_r     <= halt_pend_s;
      ir_buf_r        <= ir_buf_s;
      pc_out_r        <= pc_out_s;
      npc_out_r       <= npc_out_s;
      imem_req_r      <= (state_s == S_REQ);
      ir_ld_r         <= (state_s == S_LOAD);
      halted_r        <= (state_s == S_HALT);
    end
  end

  assign imem.imem_req  = imem_req_r;
  assign imem.imem_addr = pc_r;
  assign ir_din         = ir_buf_r;
  assign ir_ld          = ir_ld_r;
  assign pc_out         = pc_out_r;
  assign npc_out        = npc_out_r;
  assign halted         = halted_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboarded bench for pc_fetch_unit: the driver predicts each delivery from a
// transaction-level PC model, a negedge monitor pops and compares on every ir_ld.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        strobe = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0000_0000;
  logic        halt = 1'b0;
  logic [31:0] ir_din, pc_out, npc_out;
  logic        ir_ld, halted;

  logic        strobe2 = 1'b0;
  logic        tie0 = 1'b0;
  logic [31:0] tie0_32 = 32'h0000_0000;
  logic [31:0] ir_din2, pc_out2, npc_out2;
  logic        ir_ld2, halted2;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
    logic [31:0] npc;
  } deliv_t;

  deliv_t      exp_q[$];
  deliv_t      last_d = '0;
  logic        clr_q = 1'b1;
  logic [31:0] model_pc = 32'h0000_0000;

  pc_fetch_unit_if mem ();
  pc_fetch_unit_if mem2 ();

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk(clk), .clr(clr), .strobe(strobe), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .imem(mem), .ir_din(ir_din), .ir_ld(ir_ld),
    .pc_out(pc_out), .npc_out(npc_out), .halted(halted)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .clr(clr), .strobe(strobe2), .stall(tie0), .redirect(tie0),
    .redirect_pc(tie0_32), .halt(tie0), .imem(mem2), .ir_din(ir_din2), .ir_ld(ir_ld2),
    .pc_out(pc_out2), .npc_out(npc_out2), .halted(halted2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(posedge clk) clr_q <= clr;

  // Monitor: every ir_ld must match the oldest prediction; otherwise outputs must hold.
  always @(negedge clk) begin
    deliv_t d;
    if (clr_q) begin
      last_d = '0;
      check("reset_ir_ld", {31'd0, ir_ld}, 32'd0);
      check("reset_ir_din", ir_din, 32'd0);
      check("reset_pc_out", pc_out, 32'd0);
      check("reset_npc_out", npc_out, 32'd0);
      check("reset_halted", {31'd0, halted}, 32'd0);
      check("reset_imem_req", {31'd0, mem.imem_req}, 32'd0);
    end else if (ir_ld === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ir_ld", 32'd1, 32'd0);
      end else begin
        d = exp_q.pop_front();
        check("ir_din", ir_din, d.word);
        check("pc_out", pc_out, d.pc);
        check("npc_out", npc_out, d.npc);
        last_d = d;
      end
    end else begin
      check("hold_ir_din", ir_din, last_d.word);
      check("hold_pc_out", pc_out, last_d.pc);
      check("hold_npc_out", npc_out, last_d.npc);
    end
  end

  // One fetch: rc is the cycle (0..dly = REQ cycles, dly+1 = LOAD) carrying a redirect, -1 for none.
  task automatic do_fetch(input int dly, input int rc, input logic [31:0] tgt,
                          input bit hlt, input logic [31:0] word);
    logic [31:0] addr;
    addr   = model_pc;
    strobe = 1'b1;
    stall  = 1'b0;
    @(negedge clk);
    strobe = 1'b0;
    check("req_latency", {31'd0, mem.imem_req}, 32'd1);
    check("fetch_addr", mem.imem_addr, addr);
    for (int c = 0; c <= dly; c++) begin
      if (c > 0) begin
        check("req_held", {31'd0, mem.imem_req}, 32'd1);
        check("addr_stable", mem.imem_addr, addr);
      end
      redirect       = (c == rc);
      redirect_pc    = tgt;
      halt           = hlt && (c == 0);
      strobe         = 1'($urandom_range(0, 1));
      stall          = 1'($urandom_range(0, 1));
      mem.imem_ack   = (c == dly);
      mem.imem_rdata = (c == dly) ? word : $urandom;
      if (c == dly) exp_q.push_back({word, addr, addr + 32'd4});
      @(negedge clk);
    end
    redirect       = (rc == dly + 1);
    redirect_pc    = tgt;
    halt           = 1'b0;
    mem.imem_ack   = 1'($urandom_range(0, 1));
    mem.imem_rdata = $urandom;
    @(negedge clk);
    redirect     = 1'b0;
    strobe       = 1'b0;
    stall        = 1'b0;
    mem.imem_ack = 1'b0;
    model_pc = (rc >= 0) ? (tgt & 32'hFFFF_FFFC) : addr + 32'd4;
  endtask

  task automatic redirect_idle(input logic [31:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
    strobe      = 1'($urandom_range(0, 1));
    @(negedge clk);
    redirect = 1'b0;
    strobe   = 1'b0;
    check("redirect_idle_no_req", {31'd0, mem.imem_req}, 32'd0);
    model_pc = tgt & 32'hFFFF_FFFC;
  endtask

  initial begin
    mem.imem_ack    = 1'b0;
    mem.imem_rdata  = 32'h0000_0000;
    mem2.imem_ack   = 1'b0;
    mem2.imem_rdata = 32'h0000_0000;
    repeat (2) @(negedge clk);
    clr      = 1'b0;
    model_pc = 32'h0000_0000;

    do_fetch(1, -1, 32'h0, 1'b0, 32'h2001_0005);
    do_fetch(0, -1, 32'h0, 1'b0, $urandom);

    strobe = 1'b1;
    stall  = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_no_req", {31'd0, mem.imem_req}, 32'd0);
    end
    do_fetch(0, -1, 32'h0, 1'b0, $urandom);

    do_fetch(3, 0, 32'h0000_0103, 1'b0, $urandom);
    do_fetch(0, -1, 32'h0, 1'b0, $urandom);

    redirect_idle(32'hFFFF_FFFE);
    do_fetch(1, -1, 32'h0, 1'b0, $urandom);
    do_fetch(0, -1, 32'h0, 1'b0, $urandom);

    for (int t = 0; t < 40; t++) begin
      int dly;
      int rc;
      dly = $urandom_range(0, 3);
      rc  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, dly + 1) : -1;
      if ($urandom_range(0, 3) == 0) redirect_idle($urandom);
      do_fetch(dly, rc, $urandom, 1'b0, $urandom);
    end

    do_fetch(2, -1, 32'h0, 1'b1, $urandom);
    check("halt_not_yet", {31'd0, halted}, 32'd0);
    @(negedge clk);
    check("halted_set", {31'd0, halted}, 32'd1);
    strobe = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("halted_hold", {31'd0, halted}, 32'd1);
      check("halted_no_req", {31'd0, mem.imem_req}, 32'd0);
    end
    strobe = 1'b0;
    clr    = 1'b1;
    @(negedge clk);
    clr      = 1'b0;
    model_pc = 32'h0000_0000;
    check("halt_cleared", {31'd0, halted}, 32'd0);
    do_fetch(0, -1, 32'h0, 1'b0, $urandom);

    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    check("abort_req_up", {31'd0, mem.imem_req}, 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr            = 1'b0;
    mem.imem_ack   = 1'b1;
    mem.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem.imem_ack = 1'b0;
    check("abandoned_no_req", {31'd0, mem.imem_req}, 32'd0);
    repeat (2) @(negedge clk);
    model_pc = 32'h0000_0000;
    do_fetch(1, -1, 32'h0, 1'b0, $urandom);

    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check("halt_from_idle", {31'd0, halted}, 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;

    strobe2 = 1'b1;
    @(negedge clk);
    strobe2 = 1'b0;
    check("wrap_req", {31'd0, mem2.imem_req}, 32'd1);
    check("wrap_addr", mem2.imem_addr, 32'hFFFF_FFFC);
    mem2.imem_ack   = 1'b1;
    mem2.imem_rdata = 32'h1234_5678;
    @(negedge clk);
    mem2.imem_ack = 1'b0;
    check("wrap_ir_ld", {31'd0, ir_ld2}, 32'd1);
    check("wrap_ir_din", ir_din2, 32'h1234_5678);
    check("wrap_pc_out", pc_out2, 32'hFFFF_FFFC);
    check("wrap_npc_out", npc_out2, 32'h0000_0000);
    @(negedge clk);
    strobe2 = 1'b1;
    @(negedge clk);
    strobe2 = 1'b0;
    check("wrap_next_addr", mem2.imem_addr, 32'h0000_0000);
    check("wrap_halted", {31'd0, halted2}, 32'd0);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
